alu_share_arbiter: RTL



---
 rtl/alu_share_arbiter_pkg.sv | 33 +++
 rtl/alu_share_arbiter_rr.sv | 26 ++
 rtl/alu_share_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU front end: opcode map, legality check
// and FSM state encoding.
package alu_share_arbiter_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_ROL = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_ROR = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT,
            ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROL, ALU_ROR: is_legal_op = 1'b1;
            default:                                     is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Two-way round-robin arbiter; the last-grant pointer only moves when a grant is accepted.
module alu_share_arbiter_rr (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_accept,
    output logic o_grant0,
    output logic o_grant1
);

    // 1 means requester 1 was served last, so requester 0 wins the first tie after reset.
    logic r_last_grant;

    assign o_grant0 = i_valid0 & (~i_valid1 | r_last_grant);
    assign o_grant1 = i_valid1 & (~i_valid0 | ~r_last_grant);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (i_accept) begin
            r_last_grant <= o_grant1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters: arbitrate, register
// operands, wait one cycle for the ALU, then hold a tagged result until consumed.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Req0_Valid,
    output logic              Req0_Ready,
    input  logic [DATA_W-1:0] Req0_A,
    input  logic [DATA_W-1:0] Req0_B,
    input  logic [OP_W-1:0]   Req0_Op,
    input  logic              Req1_Valid,
    output logic              Req1_Ready,
    input  logic [DATA_W-1:0] Req1_A,
    input  logic [DATA_W-1:0] Req1_B,
    input  logic [OP_W-1:0]   Req1_Op,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic              Rsp_Id,
    output logic [DATA_W-1:0] Rsp_Out,
    output logic              Rsp_Zero,
    output logic              Rsp_Err,
    output logic [DATA_W-1:0] Alu_A,
    output logic [DATA_W-1:0] Alu_B,
    output logic [OP_W-1:0]   Alu_Op,
    input  logic [DATA_W-1:0] Alu_Out,
    input  logic              Alu_Zero,
    output state_t            Dbg_State
);

    // Handshakes: a request transfers on ReqX_Valid & ReqX_Ready at a rising edge; the
    // result transfers on Rsp_Valid & Rsp_Ready. Ready never depends on Ready elsewhere.
    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_op;
    logic                r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_out;
    logic                r_rsp_zero;
    logic                r_rsp_err;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [OP_W-1:0]     w_sel_op;
    logic                w_sel_legal;

    alu_share_arbiter_rr u_rr (
        .i_clk    (Clk),
        .i_rst_n  (Reset_n),
        .i_valid0 (Req0_Valid),
        .i_valid1 (Req1_Valid),
        .i_accept (w_accept),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    // Ready is gated by reset so nothing can look accepted while the block is held in reset.
    assign Req0_Ready  = Reset_n & (r_state == ST_IDLE) & w_grant0;
    assign Req1_Ready  = Reset_n & (r_state == ST_IDLE) & w_grant1;
    assign w_accept    = Req0_Ready | Req1_Ready;

    assign w_sel_a     = w_grant1 ? Req1_A  : Req0_A;
    assign w_sel_b     = w_grant1 ? Req1_B  : Req0_B;
    assign w_sel_op    = w_grant1 ? Req1_Op : Req0_Op;
    assign w_sel_legal = is_legal_op(w_sel_op);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = w_sel_legal ? ST_EXEC : ST_RESP;
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (Rsp_Ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_out  <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_rsp_id <= w_grant1;
                if (w_sel_legal) begin
                    r_alu_a  <= w_sel_a;
                    r_alu_b  <= w_sel_b;
                    r_alu_op <= w_sel_op;
                end else begin
                    // Illegal opcodes never reach the ALU; the result is produced here.
                    r_rsp_out  <= '0;
                    r_rsp_zero <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end
            end else if (r_state == ST_EXEC) begin
                r_rsp_out  <= Alu_Out;
                r_rsp_zero <= Alu_Zero;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign Alu_A     = r_alu_a;
    assign Alu_B     = r_alu_b;
    assign Alu_Op    = r_alu_op;
    assign Rsp_Valid = (r_state == ST_RESP);
    assign Rsp_Id    = r_rsp_id;
    assign Rsp_Out   = r_rsp_out;
    assign Rsp_Zero  = r_rsp_zero;
    assign Rsp_Err   = r_rsp_err;
    assign Dbg_State = r_state;

endmodule
